// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM encoding, default timing, width helper.
package reset_seq_pkg;

  localparam int ST_W     = 3;
  localparam int NSTG_DEF = 4;
  localparam int DLY_DEF  = 16;
  localparam int TMO_DEF  = 4095;

  typedef enum logic [ST_W-1:0] {
    HOLD     = 3'd0,
    SETTLE   = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } seq_state_e;

  // Index width for n stages, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (master) and the subsystems it releases (slave).
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NSTG = NSTG_DEF
);
  localparam int ESW = idx_w(NSTG);

  logic            pll_lock;
  logic            soft_req;
  logic [NSTG-1:0] stg_ack;
  logic [NSTG-1:0] stg_rst;
  logic            done;
  logic            err;
  logic [ESW-1:0]  err_stg;

  modport master (
    input  pll_lock, soft_req, stg_ack,
    output stg_rst, done, err, err_stg
  );

  modport slave (
    output pll_lock, soft_req, stg_ack,
    input  stg_rst, done, err, err_stg
  );
endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop single-bit synchronizer, resets to 0; reusable for any asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking keeps meta and q as two distinct flops; blocking would collapse the chain.
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: releases NSTG resets in order, gated by PLL lock and per-stage acks.
// Build option: define RESET_SEQ_TIMEOUT_EN to enable the per-stage ack timeout and the ERR state.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NSTG = NSTG_DEF,
  parameter int DLY  = DLY_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.master bus
);
  localparam int IW   = idx_w(NSTG);
  localparam int CMAX = (DLY > TMO) ? DLY : TMO;
  localparam int CW   = $clog2(CMAX + 1);

  seq_state_e      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NSTG-1:0] stg_rst_q, stg_rst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [IW-1:0]   err_stg_q, err_stg_d;
  logic            lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    // NOTE: every output of this block takes its held value first, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    stg_rst_d = stg_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    err_stg_d = err_stg_q;

    case (state_q)
      HOLD: begin
        stg_rst_d = '1;
        idx_d     = '0;
        cnt_d     = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_stg_d = '0;
        if (lock_s) begin
          state_d = SETTLE;
          cnt_d   = CW'(DLY - 1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          stg_rst_d[idx_q] = 1'b0;
          state_d          = WAIT_ACK;
`ifdef RESET_SEQ_TIMEOUT_EN
          cnt_d            = CW'(TMO - 1);
`else
          cnt_d            = '0;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_ACK: begin
        // An ack on the final edge of the timeout window still counts.
        if (bus.stg_ack[idx_q]) begin
          if (idx_q == IW'(NSTG - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = SETTLE;
            cnt_d   = CW'(DLY - 1);
          end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d   = ERR;
          err_d     = 1'b1;
          err_stg_d = idx_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`endif
      end
      DONE: ;
`ifdef RESET_SEQ_TIMEOUT_EN
      ERR: ;
`endif
      default: state_d = HOLD;
    endcase

    // Restart overrides any ack or timeout decided above.
    if (bus.soft_req || (!lock_s && state_q != HOLD)) begin
      state_d   = HOLD;
      idx_d     = '0;
      cnt_d     = '0;
      stg_rst_d = '1;
      done_d    = 1'b0;
      err_d     = 1'b0;
      err_stg_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HOLD;
      idx_q     <= '0;
      cnt_q     <= '0;
      stg_rst_q <= '1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_stg_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      stg_rst_q <= stg_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_stg_q <= err_stg_d;
    end
  end

  assign bus.stg_rst = stg_rst_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.err_stg = err_stg_q;

endmodule
